// File: rtl/interrupt_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: FSM state encoding, cause width
// and cause index constants.
package interrupt_arbiter_pkg;

    localparam int CAUSE_W = 3;
    localparam int MAX_SRC = 1 << CAUSE_W;

    typedef logic [CAUSE_W-1:0] cause_t;

    localparam cause_t IRQ_IDX_NONE = cause_t'(0);
    localparam cause_t IRQ_IDX_LAST = cause_t'(MAX_SRC - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_SERVICE  = 2'd2,
        ST_HANDLER  = 2'd3
    } arb_state_e;

endpackage : interrupt_arbiter_pkg

// File: rtl/interrupt_arbiter_irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins and is reported as a
// cause index together with a valid flag.
module irq_prio_enc
    import interrupt_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output cause_t             idx
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        valid = |req;
        idx   = IRQ_IDX_NONE;
        // Scan from the top down so the lowest set index is written last.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = CAUSE_W'(i);
            end
        end
    end

endmodule : irq_prio_enc

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: masks request lines, picks a fixed-priority winner and
// drives the trap-entry handshake until mret. Define INTARB_EDGE_EN for edge-latched pending.
module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               rdy_in,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] irq_enable_in,
    input  logic               global_ie_in,
    input  logic               seq_busy_in,
    input  logic               mret_in,
    output logic               interrupt_enable_out,
    output cause_t             interrupt_cause_out,
    output logic               in_handler_out,
    output logic [NUM_SRC-1:0] pending_out,
    output logic               ack_error_out
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               int_en_q, int_en_d;
    cause_t             cause_q, cause_d;
    logic               in_handler_q, in_handler_d;
    logic               ack_err_q, ack_err_d;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] eligible;
    logic               win_valid;
    cause_t             win_idx;
    logic               issue;

`ifdef INTARB_EDGE_EN
    logic [NUM_SRC-1:0] irq_prev_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] issue_clr;

    always_comb begin
        issue_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            issue_clr[i] = issue && (win_idx == CAUSE_W'(i));
        end
    end

    // A new rising edge is OR-ed in after the clear, so set beats clear on the same bit.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
        end else if (rdy_in) begin
            irq_prev_q <= irq_in;
            pending_q  <= (pending_q & ~issue_clr) | (irq_in & ~irq_prev_q);
        end
    end

    assign pending = pending_q;
`else
    assign pending = irq_in;
`endif

    assign eligible = pending & irq_enable_in & {NUM_SRC{global_ie_in}};

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req   (eligible),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        int_en_d     = 1'b0;
        cause_d      = cause_q;
        in_handler_d = in_handler_q;
        ack_err_d    = 1'b0;
        issue        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    issue        = 1'b1;
                    int_en_d     = 1'b1;
                    cause_d      = win_idx;
                    in_handler_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (seq_busy_in) begin
                    state_d = ST_SERVICE;
                end else if (cnt_q == CNT_LAST) begin
                    ack_err_d    = 1'b1;
                    in_handler_d = 1'b0;
                    cause_d      = IRQ_IDX_NONE;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SERVICE: begin
                if (!seq_busy_in) begin
                    state_d = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                if (mret_in) begin
                    in_handler_d = 1'b0;
                    cause_d      = IRQ_IDX_NONE;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    // With rdy_in low nothing updates, so a pending pulse is held rather than repeated.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            int_en_q     <= 1'b0;
            cause_q      <= IRQ_IDX_NONE;
            in_handler_q <= 1'b0;
            ack_err_q    <= 1'b0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            int_en_q     <= int_en_d;
            cause_q      <= cause_d;
            in_handler_q <= in_handler_d;
            ack_err_q    <= ack_err_d;
        end
    end

    assign interrupt_enable_out = int_en_q;
    assign interrupt_cause_out  = cause_q;
    assign in_handler_out       = in_handler_q;
    assign ack_error_out        = ack_err_q;
    assign pending_out          = pending;

endmodule : interrupt_arbiter

// File: tb/tb_interrupt_arbiter.sv
// Directed self-checking bench for interrupt_arbiter; follows INTARB_EDGE_EN for mode-specific expectations.
module tb_interrupt_arbiter;

`ifdef INTARB_EDGE_EN
    localparam int EDGE_LAT = 1;
    localparam bit EDGE     = 1'b1;
`else
    localparam int EDGE_LAT = 0;
    localparam bit EDGE     = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       rdy_in;
    logic [7:0] irq_in;
    logic [7:0] irq_enable_in;
    logic       global_ie_in;
    logic       seq_busy_in;
    logic       mret_in;
    logic       interrupt_enable_out;
    logic [2:0] interrupt_cause_out;
    logic       in_handler_out;
    logic [7:0] pending_out;
    logic       ack_error_out;

    int errors = 0;
    int checks = 0;

    interrupt_arbiter #(
        .NUM_SRC     (8),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk_in               (clk_in),
        .rst_n_in             (rst_n_in),
        .rdy_in               (rdy_in),
        .irq_in               (irq_in),
        .irq_enable_in        (irq_enable_in),
        .global_ie_in         (global_ie_in),
        .seq_busy_in          (seq_busy_in),
        .mret_in              (mret_in),
        .interrupt_enable_out (interrupt_enable_out),
        .interrupt_cause_out  (interrupt_cause_out),
        .in_handler_out       (in_handler_out),
        .pending_out          (pending_out),
        .ack_error_out        (ack_error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Drive the sequencer handshake and mret from WAIT_ACK back to IDLE.
    task automatic finish_seq();
        seq_busy_in = 1'b1;
        step(1);
        seq_busy_in = 1'b0;
        step(1);
        mret_in = 1'b1;
        step(1);
        mret_in = 1'b0;
    endtask

    initial begin
        rst_n_in      = 1'b0;
        rdy_in        = 1'b1;
        irq_in        = 8'h00;
        irq_enable_in = 8'hFF;
        global_ie_in  = 1'b1;
        seq_busy_in   = 1'b0;
        mret_in       = 1'b0;
        step(2);
        check("rst_int_en",  interrupt_enable_out, 0);
        check("rst_cause",   interrupt_cause_out, 0);
        check("rst_in_hdl",  in_handler_out, 0);
        check("rst_pending", pending_out, 0);
        check("rst_ack_err", ack_error_out, 0);
        rst_n_in = 1'b1;
        step(1);

        // 1: single source, three busy cycles, then mret
        irq_in = 8'h01;
        step(EDGE_LAT + 1);
        check("t1_pulse", interrupt_enable_out, 1);
        check("t1_cause", interrupt_cause_out, 0);
        check("t1_in_hdl", in_handler_out, 1);
        irq_in = 8'h00;
        seq_busy_in = 1'b1;
        step(1);
        check("t1_pulse_one_cycle", interrupt_enable_out, 0);
        step(2);
        seq_busy_in = 1'b0;
        step(1);
        check("t1_in_hdl_handler", in_handler_out, 1);
        mret_in = 1'b1;
        step(1);
        mret_in = 1'b0;
        check("t1_in_hdl_after_mret", in_handler_out, 0);
        step(1);
        check("t1_idle_no_pulse", interrupt_enable_out, 0);

        // 2: priority between bits 2 and 5
        irq_in = 8'h24;
        step(EDGE_LAT + 1);
        check("t2_cause2", interrupt_cause_out, 2);
        seq_busy_in = 1'b1;
        step(1);
        seq_busy_in = 1'b0;
        step(1);
        irq_in  = 8'h20;
        mret_in = 1'b1;
        step(1);
        mret_in = 1'b0;
        check("t2_mret_in_hdl", in_handler_out, 0);
        step(1);
        check("t2_pulse5", interrupt_enable_out, 1);
        check("t2_cause5", interrupt_cause_out, 5);
        irq_in = 8'h00;
        finish_seq();

        // 3: global enable masks, pending still visible
        global_ie_in = 1'b0;
        irq_in       = 8'h08;
        step(EDGE_LAT + 1);
        check("t3_masked_no_pulse", interrupt_enable_out, 0);
        check("t3_pending", pending_out, 8'h08);
        global_ie_in = 1'b1;
        step(1);
        check("t3_pulse", interrupt_enable_out, 1);
        check("t3_cause3", interrupt_cause_out, 3);
        irq_in = 8'h00;
        finish_seq();

        // 4: acknowledge timeout
        irq_in = 8'h02;
        step(EDGE_LAT + 1);
        check("t4_pulse", interrupt_enable_out, 1);
        irq_in = 8'h00;
        step(3);
        check("t4_no_err_early", ack_error_out, 0);
        step(1);
        check("t4_ack_err", ack_error_out, 1);
        check("t4_in_hdl", in_handler_out, 0);
        check("t4_cause_clr", interrupt_cause_out, 0);
        step(1);
        check("t4_ack_err_one_cycle", ack_error_out, 0);

        // 5: rdy_in freezes WAIT_ACK and HANDLER
        irq_in = 8'h01;
        step(EDGE_LAT + 1);
        irq_in = 8'h00;
        rdy_in = 1'b0;
        step(5);
        check("t5_pulse_held", interrupt_enable_out, 1);
        check("t5_no_timeout_frozen", ack_error_out, 0);
        rdy_in      = 1'b1;
        seq_busy_in = 1'b1;
        step(1);
        check("t5_to_service_no_err", ack_error_out, 0);
        check("t5_pulse_drop", interrupt_enable_out, 0);
        seq_busy_in = 1'b0;
        step(1);
        rdy_in  = 1'b0;
        mret_in = 1'b1;
        step(2);
        check("t5_mret_ignored_frozen", in_handler_out, 1);
        mret_in = 1'b0;
        rdy_in  = 1'b1;
        step(1);
        check("t5_still_handler", in_handler_out, 1);
        mret_in = 1'b1;
        step(1);
        mret_in = 1'b0;
        check("t5_mret_taken", in_handler_out, 0);

        // 6: short pulse while in HANDLER
        irq_in = 8'h01;
        step(EDGE_LAT + 1);
        irq_in = 8'h00;
        seq_busy_in = 1'b1;
        step(1);
        seq_busy_in = 1'b0;
        step(1);
        irq_in = 8'h02;
        step(1);
        irq_in = 8'h00;
        step(1);
        check("t6_pending_kept", pending_out, EDGE ? 8'h02 : 8'h00);
        mret_in = 1'b1;
        step(1);
        mret_in = 1'b0;
        check("t6_mret", in_handler_out, 0);
        step(1);
        check("t6_late_pulse", interrupt_enable_out, EDGE ? 1 : 0);
        check("t6_late_cause", interrupt_cause_out, EDGE ? 1 : 0);
        if (EDGE) finish_seq();

        // 6b: asynchronous reset mid-SERVICE
        irq_in = 8'h01;
        step(EDGE_LAT + 1);
        irq_in = 8'h00;
        seq_busy_in = 1'b1;
        step(1);
        check("t6_in_service", in_handler_out, 1);
        rst_n_in = 1'b0;
        #1;
        check("t6_rst_int_en",  interrupt_enable_out, 0);
        check("t6_rst_cause",   interrupt_cause_out, 0);
        check("t6_rst_in_hdl",  in_handler_out, 0);
        check("t6_rst_ack_err", ack_error_out, 0);
        check("t6_rst_pending", pending_out, 0);
        seq_busy_in = 1'b0;
        step(1);
        rst_n_in = 1'b1;
        step(2);
        check("t6_post_rst_idle", interrupt_enable_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_interrupt_arbiter
